// File: rtl/multicycle_sequencer_if.sv
// Memory port bundle for multicycle_sequencer: request/ready handshake with
// a single address, write-data and read-data bus.
interface multicycle_sequencer_if;
    localparam int unsigned DW = 16;

    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 16-bit datapath: fetch, decode, execute,
// memory and writeback, with all control outputs registered from next-state values.
module multicycle_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    multicycle_sequencer_if.master mem,
    output logic [1:0]             rr1,
    output logic [1:0]             rr2,
    input  logic [15:0]            rd1,
    input  logic [15:0]            rd2,
    output logic [1:0]             wr,
    output logic [15:0]            wd,
    output logic                   regwrite,
    output logic [2:0]             alu_op,
    output logic [15:0]            alu_a,
    output logic [15:0]            alu_b,
    input  logic [15:0]            alu_result,
    input  logic                   alu_zero,
    output logic [15:0]            pc,
    output logic [2:0]             state,
    output logic                   halted,
    output logic                   illegal
);
    localparam int unsigned DW = 16;
    localparam int unsigned RW = 2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    function automatic logic is_rtype(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT};
    endfunction

    function automatic logic is_known(input logic [3:0] op);
        return is_rtype(op) || (op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT});
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            OP_SUB, OP_BEQ: return 3'b110;
            OP_AND:         return 3'b000;
            OP_OR:          return 3'b001;
            OP_SLT:         return 3'b111;
            default:        return 3'b010;
        endcase
    endfunction

    function automatic logic [DW-1:0] sext(input logic [7:0] imm);
        return {{(DW-8){imm[7]}}, imm};
    endfunction

    state_t        st, st_n;
    logic [DW-1:0] pc_q, pc_n, ir_q, ir_n, a_q, a_n, b_q, b_n;
    logic [DW-1:0] aluout_q, aluout_n, mdr_q, mdr_n;
    logic [3:0]    op, op_n;
    logic          mem_req_q, mem_req_n, mem_we_q, mem_we_n;
    logic [DW-1:0] mem_addr_q, mem_addr_n, alu_b_q, alu_b_n, wd_q, wd_n;
    logic [2:0]    alu_op_q, alu_op_n;
    logic [RW-1:0] wr_q, wr_n;
    logic          regwrite_q, regwrite_n, halted_q, halted_n, illegal_q, illegal_n;

    assign op = ir_q[15:12];

    // Next-state and holding-register updates; output registers follow from the next values
    always_comb begin
        st_n       = st;
        pc_n       = pc_q;
        ir_n       = ir_q;
        a_n        = a_q;
        b_n        = b_q;
        aluout_n   = aluout_q;
        mdr_n      = mdr_q;
        illegal_n  = 1'b0;
        case (st)
            S_RST: st_n = S_FETCH;
            S_FETCH: begin
                if (mem.mem_ready) begin
                    ir_n      = mem.mem_rdata;
                    pc_n      = pc_q + DW'(1);
                    st_n      = S_DECODE;
                    illegal_n = !is_known(mem.mem_rdata[15:12]);
                end
            end
            S_DECODE: begin
                a_n = rd1;
                b_n = rd2;
                if (op == OP_HALT)    st_n = S_HALT;
                else if (!is_known(op)) st_n = S_FETCH;
                else                  st_n = S_EXEC;
            end
            S_EXEC: begin
                aluout_n = alu_result;
                if (op == OP_BEQ) begin
                    if (alu_zero) pc_n = pc_q + sext(ir_q[7:0]);
                    st_n = S_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    st_n = S_MEM;
                end else begin
                    st_n = S_WB;
                end
            end
            S_MEM: begin
                if (mem.mem_ready) begin
                    if (op == OP_LW) begin
                        mdr_n = mem.mem_rdata;
                        st_n  = S_WB;
                    end else begin
                        st_n  = S_FETCH;
                    end
                end
            end
            S_WB:    st_n = S_FETCH;
            S_HALT:  st_n = S_HALT;
            default: st_n = S_RST;
        endcase

        op_n       = ir_n[15:12];
        mem_req_n  = (st_n == S_FETCH) || (st_n == S_MEM);
        mem_we_n   = (st_n == S_MEM) && (op_n == OP_SW);
        mem_addr_n = (st_n == S_FETCH) ? pc_n : aluout_n;
        alu_b_n    = (op_n inside {OP_ADDI, OP_LW, OP_SW}) ? sext(ir_n[7:0]) : b_n;
        alu_op_n   = alu_code(op_n);
        wr_n       = is_rtype(op_n) ? ir_n[7:6] : ir_n[9:8];
        wd_n       = (op_n == OP_LW) ? mdr_n : aluout_n;
        regwrite_n = (st_n == S_WB) && (wr_n != RW'(0));
        halted_n   = (st_n == S_HALT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st         <= S_RST;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            aluout_q   <= '0;
            mdr_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            wr_q       <= '0;
            wd_q       <= '0;
            regwrite_q <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            st         <= st_n;
            pc_q       <= pc_n;
            ir_q       <= ir_n;
            a_q        <= a_n;
            b_q        <= b_n;
            aluout_q   <= aluout_n;
            mdr_q      <= mdr_n;
            mem_req_q  <= mem_req_n;
            mem_we_q   <= mem_we_n;
            mem_addr_q <= mem_addr_n;
            alu_b_q    <= alu_b_n;
            alu_op_q   <= alu_op_n;
            wr_q       <= wr_n;
            wd_q       <= wd_n;
            regwrite_q <= regwrite_n;
            halted_q   <= halted_n;
            illegal_q  <= illegal_n;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = b_q;
    assign rr1           = ir_q[11:10];
    assign rr2           = ir_q[9:8];
    assign wr            = wr_q;
    assign wd            = wd_q;
    assign regwrite      = regwrite_q;
    assign alu_op        = alu_op_q;
    assign alu_a         = a_q;
    assign alu_b         = alu_b_q;
    assign pc            = pc_q;
    assign state         = st;
    assign halted        = halted_q;
    assign illegal       = illegal_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: memory, register file and ALU models around
// the sequencer, a table of small programs, and hand-written corner sequences.
module tb_multicycle_sequencer;
    typedef struct {
        logic [15:0] w0, w1, w2, w3;
        logic [15:0] xa, xd;
        int          waits;
        int          cycles;
        logic [15:0] pc;
        logic [15:0] r1, r2, r3;
        int          wcnt, rwcnt, icnt;
        logic [15:0] waddr, wdata;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rr1, rr2, wr;
    logic [15:0] rd1, rd2, wd, alu_a, alu_b, alu_result, pc;
    logic        regwrite, alu_zero, halted, illegal;
    logic [2:0]  alu_op, state;

    multicycle_sequencer_if bus ();

    multicycle_sequencer dut (
        .clock(clock), .reset_n(reset_n), .mem(bus.master),
        .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
        .wr(wr), .wd(wd), .regwrite(regwrite),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .pc(pc), .state(state), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // Environment models: memory with wait states, register file, ALU
    logic [15:0] mem [0:65535];
    logic [15:0] regs [0:3];
    vec_t        cur;
    logic        load = 1'b0;
    int          waits = 0;
    int          wait_cnt, wcnt, rwcnt, icnt, bad;
    logic [15:0] waddr_last, wdata_last, stall_addr;
    logic        stall_prev;

    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.mem_ready = bus.mem_req && (wait_cnt == waits);
    assign rd1 = regs[rr1];
    assign rd2 = regs[rr2];

    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            3'b111:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
            default: alu_result = 16'hDEAD;
        endcase
        alu_zero = (alu_result == 16'd0);
    end

    always @(posedge clock) begin
        if (load) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'hF000;
            mem[0] <= cur.w0;
            mem[1] <= cur.w1;
            mem[2] <= cur.w2;
            mem[3] <= cur.w3;
            mem[cur.xa] <= cur.xd;
            for (int i = 0; i < 4; i++) regs[i] <= 16'd0;
            wait_cnt   <= 0;
            wcnt       <= 0;
            rwcnt      <= 0;
            icnt       <= 0;
            bad        <= 0;
            waddr_last <= 16'd0;
            wdata_last <= 16'd0;
            stall_prev <= 1'b0;
            stall_addr <= 16'd0;
        end else begin
            if (bus.mem_req && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_wdata;
                wcnt       <= wcnt + 1;
                waddr_last <= bus.mem_addr;
                wdata_last <= bus.mem_wdata;
            end
            if (regwrite) begin
                rwcnt <= rwcnt + 1;
                if (wr != 2'd0) regs[wr] <= wd;
            end
            if (illegal) icnt <= icnt + 1;
            if (stall_prev && bus.mem_req && bus.mem_addr != stall_addr) bad <= bad + 1;
            stall_prev <= bus.mem_req && !bus.mem_ready;
            stall_addr <= bus.mem_addr;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [15:0] i0, i1, i2, i3, ia, id,
        input int nw, nc, input logic [15:0] epc, e1, e2, e3,
        input int ew, erw, eil, input logic [15:0] ewa, ewd);
        vec_t v;
        v.w0 = i0; v.w1 = i1; v.w2 = i2; v.w3 = i3; v.xa = ia; v.xd = id;
        v.waits = nw; v.cycles = nc; v.pc = epc; v.r1 = e1; v.r2 = e2; v.r3 = e3;
        v.wcnt = ew; v.rwcnt = erw; v.icnt = eil; v.waddr = ewa; v.wdata = ewd;
        return v;
    endfunction

    task automatic start(input vec_t v, input bit chk_reset);
        reset_n = 1'b0;
        cur     = v;
        waits   = v.waits;
        load    = 1'b1;
        @(posedge clock);
        #1 load = 1'b0;
        if (chk_reset) begin
            check("reset.state", 32'(state), 32'd0);
            check("reset.pc", 32'(pc), 32'h0000);
            check("reset.mem_req", 32'(bus.mem_req), 32'd0);
            check("reset.regwrite", 32'(regwrite), 32'd0);
            check("reset.halted", 32'(halted), 32'd0);
            check("reset.illegal", 32'(illegal), 32'd0);
            check("reset.wr_wd", {14'd0, wr, wd}, 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int n;
        start(v, id == 0);
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clock);
            #1;
            if (halted) begin
                n = k;
                break;
            end
        end
        check($sformatf("v%0d.cycles", id), 32'(n), 32'(v.cycles));
        check($sformatf("v%0d.pc", id), 32'(pc), 32'(v.pc));
        check($sformatf("v%0d.r1", id), 32'(regs[1]), 32'(v.r1));
        check($sformatf("v%0d.r2", id), 32'(regs[2]), 32'(v.r2));
        check($sformatf("v%0d.r3", id), 32'(regs[3]), 32'(v.r3));
        check($sformatf("v%0d.memwrites", id), 32'(wcnt), 32'(v.wcnt));
        check($sformatf("v%0d.regwrites", id), 32'(rwcnt), 32'(v.rwcnt));
        check($sformatf("v%0d.illegal", id), 32'(icnt), 32'(v.icnt));
        check($sformatf("v%0d.stall_addr", id), 32'(bad), 32'd0);
        if (v.wcnt > 0) begin
            check($sformatf("v%0d.waddr", id), 32'(waddr_last), 32'(v.waddr));
            check($sformatf("v%0d.wdata", id), 32'(wdata_last), 32'(v.wdata));
        end
    endtask

    vec_t vecs [12];

    initial begin
        vec_t v;
        int   found;
        // add program, zero-wait and two wait states per request
        vecs[0]  = mk(16'h4105, 16'h4203, 16'h06C0, 16'hF000, 16'h0100, 16'hF000, 0, 15, 16'd4, 16'd5, 16'd3, 16'd8, 0, 3, 0, 16'd0, 16'd0);
        vecs[1]  = mk(16'h4105, 16'h4203, 16'h06C0, 16'hF000, 16'h0100, 16'hF000, 2, 23, 16'd4, 16'd5, 16'd3, 16'd8, 0, 3, 0, 16'd0, 16'd0);
        // addi r1; sw r1 -> M[16]; lw r2 <- M[16]
        vecs[2]  = mk(16'h4105, 16'h6110, 16'h5210, 16'hF000, 16'h0100, 16'hF000, 0, 16, 16'd4, 16'd5, 16'd5, 16'd0, 1, 2, 0, 16'd16, 16'd5);
        // beq r0,r0,+9 to PC 10; beq r1,r1,+2 -> halt at 13
        vecs[3]  = mk(16'h8009, 16'hF000, 16'hF000, 16'hF000, 16'h000A, 16'h8502, 0, 9, 16'd14, 16'd0, 16'd0, 16'd0, 0, 0, 0, 16'd0, 16'd0);
        // addi r1; jump to 10; beq r1,r2 not taken -> halt at 11
        vecs[4]  = mk(16'h4105, 16'h8008, 16'hF000, 16'hF000, 16'h000A, 16'h8605, 0, 13, 16'd12, 16'd5, 16'd0, 16'd0, 0, 1, 0, 16'd0, 16'd0);
        // jump to FFFF, halt there: PC wraps to 0
        vecs[5]  = mk(16'h80FE, 16'hF000, 16'hF000, 16'hF000, 16'hFFFF, 16'hF000, 0, 6, 16'h0000, 16'd0, 16'd0, 16'd0, 0, 0, 0, 16'd0, 16'd0);
        // undefined opcode 1010 then halt
        vecs[6]  = mk(16'hA000, 16'hF000, 16'hF000, 16'hF000, 16'h0100, 16'hF000, 0, 5, 16'd2, 16'd0, 16'd0, 16'd0, 0, 0, 1, 16'd0, 16'd0);
        // add r0,r1,r2: no regwrite
        vecs[7]  = mk(16'h4105, 16'h4203, 16'h0600, 16'hF000, 16'h0100, 16'hF000, 0, 15, 16'd4, 16'd5, 16'd3, 16'd0, 0, 2, 0, 16'd0, 16'd0);
        // sub r3,r2,r1 = 3-5
        vecs[8]  = mk(16'h4105, 16'h4203, 16'h19C0, 16'hF000, 16'h0100, 16'hF000, 0, 15, 16'd4, 16'd5, 16'd3, 16'hFFFE, 0, 3, 0, 16'd0, 16'd0);
        // slt r3,r2,r1 = (3<5)
        vecs[9]  = mk(16'h4105, 16'h4203, 16'h79C0, 16'hF000, 16'h0100, 16'hF000, 0, 15, 16'd4, 16'd5, 16'd3, 16'd1, 0, 3, 0, 16'd0, 16'd0);
        // or r3,r1,r2 = 5|3
        vecs[10] = mk(16'h4105, 16'h4203, 16'h36C0, 16'hF000, 16'h0100, 16'hF000, 0, 15, 16'd4, 16'd5, 16'd3, 16'd7, 0, 3, 0, 16'd0, 16'd0);
        // sw/lw with one wait state: 6 requests add 6 cycles
        vecs[11] = mk(16'h4105, 16'h6110, 16'h5210, 16'hF000, 16'h0100, 16'hF000, 1, 22, 16'd4, 16'd5, 16'd5, 16'd0, 1, 2, 0, 16'd16, 16'd5);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // beq imm=FF at PC FFFF branches to itself forever
        v = mk(16'h80FE, 16'hF000, 16'hF000, 16'hF000, 16'hFFFF, 16'h80FF, 0, 0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 16'd0, 16'd0);
        start(v, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        check("loop.first_pc", 32'(pc), 32'h0000FFFF);
        check("loop.first_state", 32'(state), 32'd1);
        check("loop.first_addr", 32'(bus.mem_addr), 32'h0000FFFF);
        @(posedge clock);
        #1;
        check("loop.pc_wrap", 32'(pc), 32'h00000000);
        repeat (2) @(posedge clock);
        #1;
        check("loop.again_pc", 32'(pc), 32'h0000FFFF);
        check("loop.again_state", 32'(state), 32'd1);
        check("loop.again_addr", 32'(bus.mem_addr), 32'h0000FFFF);
        check("loop.halted", 32'(halted), 32'd0);

        // Reset asserted between edges while a store is waiting in MEM
        v = mk(16'h4105, 16'h6110, 16'hF000, 16'hF000, 16'h0100, 16'hF000, 3, 0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 16'd0, 16'd0);
        start(v, 1'b0);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock);
            #1;
            if (state == 3'd4) begin
                found = 1;
                break;
            end
        end
        check("abort.reached_mem", 32'(found), 32'd1);
        check("abort.req_before", 32'(bus.mem_req), 32'd1);
        check("abort.we_before", 32'(bus.mem_we), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort.req_dropped", 32'(bus.mem_req), 32'd0);
        check("abort.state", 32'(state), 32'd0);
        check("abort.pc", 32'(pc), 32'h0000);
        repeat (2) @(posedge clock);
        #1;
        check("abort.no_write", 32'(wcnt), 32'd0);
        check("abort.mem16", 32'(mem[16]), 32'h0000F000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
